mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequencer between the MEM pipeline stage and an external 16-bit-wide SRAM that replaces the single-cycle data memory. It splits each 32-bit load/store into two half-word SRAM accesses, inserts configurable wait states, and drives a ready signal that the hazard/freeze logic uses to stall IF through MEM until the access completes. Sits inside the MEM stage; the ALU result is the address and valRm is the store data.

Parameters:
BASE_ADDR, 1024, byte address mapped to SRAM half-word 0
ADDR_W, 18, SRAM half-word address width
WAIT_CYCLES, 2, cycles each half access is held on the SRAM bus (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
rdEn  input  1  load request from MEM stage (memREn)
wrEn  input  1  store request from MEM stage (memWEn)
address  input  32  byte address (ALU result)
writeData  input  32  store data (valRm)
readData  output  32  load result, registered
ready  output  1  access complete / no access pending; freeze = ~ready
sramAddr  output  ADDR_W  SRAM half-word address
sramDqOut  output  16  SRAM write data
sramDqIn  input  16  SRAM read data
sramDqOe  output  1  1 = controller drives DQ bus
sramWeN  output  1  SRAM write enable, active low
sramOeN  output  1  SRAM output enable, active low

Behaviour:
- Clock: clk. Reset: rst is asynchronous and active-low.
- Reset (rst low, any state, including mid-access): state IDLE, wait counter 0, readData=0, sramAddr=0, sramDqOut=0, sramDqOe=0, sramWeN=1, sramOeN=1, ready=1. An interrupted access is abandoned, not resumed.
- Address map: wordIdx = (address - BASE_ADDR) >> 2, truncated to ADDR_W-1 bits (wraps modulo SRAM size). Low half-word is at {wordIdx,0} = bits [15:0]; high half-word is at {wordIdx,1} = bits [31:16]. address[1:0] is ignored.
- Request: req = rdEn | wrEn. wrEn has priority when both are high, and no read is performed. address, writeData, rdEn and wrEn are held stable by the frozen pipeline until ready=1. The controller registers op, wordIdx and writeData on leaving IDLE.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if req, go to LO and clear counter; otherwise stay.
  - LO: held WAIT_CYCLES cycles; on the last one, go to HI and clear counter.
  - HI: held WAIT_CYCLES cycles; on the last one, go to DONE.
  - DONE: one cycle, then IDLE unconditionally.
- ready (combinational): 1 in DONE; in IDLE equals ~req; 0 in LO and HI. A request arriving in IDLE therefore freezes the pipeline in the same cycle.
- Latency: request first seen in IDLE at cycle 0 gives ready=0 for cycles 0..2*WAIT_CYCLES and ready=1 in cycle 2*WAIT_CYCLES+1 (cycle 5 at default). The pipeline advances on that edge.
- SRAM drive in LO/HI: sramAddr = current half address.
  - Write: sramDqOe=1, sramWeN=0, sramOeN=1, sramDqOut = selected half of the latched writeData.
  - Read: sramDqOe=0, sramWeN=1, sramOeN=0.
- SRAM drive in IDLE/DONE: sramWeN=1, sramOeN=1, sramDqOe=0. sramAddr holds its last value.
- Read capture: sramDqIn is sampled on the last cycle of LO into readData[15:0] and on the last cycle of HI into readData[31:16]. readData is stable from DONE until the next read's LO capture. Writes never modify readData.
- Back-to-back accesses: after DONE there is always one IDLE cycle. A held request then starts a new access, which is the next instruction because the pipeline advanced on ready.
- No request in IDLE: all SRAM outputs stay inactive and ready=1.

Test Plan:
- Reset: assert rst=0 mid-LO of a write -> sramWeN=1, sramDqOe=0, ready=1, readData=0 immediately (asynchronous). After release with no request, ready=1 and state IDLE.
- Store: wrEn=1, address=1028, writeData=0xDEADBEEF, WAIT_CYCLES=2. Expect:
  - sramAddr=2, sramDqOut=0xBEEF, sramWeN=0 for cycles 1-2;
  - sramAddr=3, sramDqOut=0xDEAD for cycles 3-4;
  - ready=0 in cycles 0-4 and ready=1 in cycle 5;
  - sramWeN=1 in cycle 5.
- Load: SRAM model holds 0x1234 at half-word 2 and 0xABCD at half-word 3; rdEn=1, address=1028 -> sramOeN=0, sramDqOe=0, readData=0xABCD1234 in the ready cycle, and it holds after rdEn drops.
- Simultaneous rdEn=1 and wrEn=1 -> a write is performed, sramOeN stays 1 and readData is unchanged.
- Back-to-back: a store then a load held across DONE -> exactly one IDLE cycle (ready=0) between accesses; the second access completes with correct data.
- Wrap/param: WAIT_CYCLES=1 and address=BASE_ADDR+(2^ADDR_W)*2 -> sramAddr wraps to 0/1 and ready rises in cycle 3.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// MEM-stage request and 16-bit SRAM bus bundle for mem_access_ctrl.
// master = pipeline/SRAM side, slave = the controller.
interface mem_access_ctrl_if #(
   parameter int unsigned ADDR_W = 18
);
   logic              rdEn;
   logic              wrEn;
   logic [31:0]       address;
   logic [31:0]       writeData;
   logic [31:0]       readData;
   logic              ready;
   logic [ADDR_W-1:0] sramAddr;
   logic [15:0]       sramDqOut;
   logic [15:0]       sramDqIn;
   logic              sramDqOe;
   logic              sramWeN;
   logic              sramOeN;

   modport master (
      output rdEn, wrEn, address, writeData, sramDqIn,
      input  readData, ready, sramAddr, sramDqOut, sramDqOe, sramWeN, sramOeN
   );

   modport slave (
      input  rdEn, wrEn, address, writeData, sramDqIn,
      output readData, ready, sramAddr, sramDqOut, sramDqOe, sramWeN, sramOeN
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Splits 32-bit MEM-stage loads/stores into two wait-stated 16-bit SRAM accesses
// and drives ready so the pipeline freezes until the access completes.
module mem_access_ctrl #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned ADDR_W      = 18,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic              clk,
   input logic              rst,
   mem_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

   localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

   state_e            stateQ, stateD;
   logic [3:0]        cntQ, cntD;
   logic              isWrQ, isWrD;
   logic [31:0]       wDataQ, wDataD;
   logic [31:0]       readDataQ, readDataD;
   logic [ADDR_W-1:0] sramAddrQ, sramAddrD;
   logic [15:0]       dqOutQ, dqOutD;

   logic              req;
   logic              lastCycle;
   logic              busy;
   logic [31:0]       offset;
   logic [ADDR_W-2:0] reqIdx;
   logic              unusedOffset;

   // Word index wraps modulo the SRAM size; the byte offset within a word is ignored.
   assign offset       = bus.address - 32'(BASE_ADDR);
   assign reqIdx       = offset[ADDR_W:2];
   assign unusedOffset = ^{offset[31:ADDR_W+1], offset[1:0]};

   assign req       = bus.rdEn | bus.wrEn;
   assign lastCycle = (cntQ == LastCnt);

   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      isWrD     = isWrQ;
      wDataD    = wDataQ;
      readDataD = readDataQ;
      sramAddrD = sramAddrQ;
      dqOutD    = dqOutQ;
      unique case (stateQ)
         StIdle: begin
            if (req) begin
               stateD    = StLo;
               cntD      = 4'd0;
               isWrD     = bus.wrEn;
               wDataD    = bus.writeData;
               sramAddrD = {reqIdx, 1'b0};
               if (bus.wrEn) begin
                  dqOutD = bus.writeData[15:0];
               end
            end
         end
         StLo: begin
            if (lastCycle) begin
               stateD    = StHi;
               cntD      = 4'd0;
               sramAddrD = {sramAddrQ[ADDR_W-1:1], 1'b1};
               if (isWrQ) begin
                  dqOutD = wDataQ[31:16];
               end else begin
                  readDataD[15:0] = bus.sramDqIn;
               end
            end else begin
               cntD = cntQ + 4'd1;
            end
         end
         StHi: begin
            if (lastCycle) begin
               stateD = StDone;
               if (!isWrQ) begin
                  readDataD[31:16] = bus.sramDqIn;
               end
            end else begin
               cntD = cntQ + 4'd1;
            end
         end
         StDone: begin
            stateD = StIdle;
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ    <= StIdle;
         cntQ      <= 4'd0;
         isWrQ     <= 1'b0;
         wDataQ    <= 32'd0;
         readDataQ <= 32'd0;
         sramAddrQ <= '0;
         dqOutQ    <= 16'd0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         isWrQ     <= isWrD;
         wDataQ    <= wDataD;
         readDataQ <= readDataD;
         sramAddrQ <= sramAddrD;
         dqOutQ    <= dqOutD;
      end
   end

   // A fresh request in IDLE drops ready in the same cycle so the pipeline freezes at once.
   assign busy          = (stateQ == StLo) || (stateQ == StHi);
   assign bus.ready     = (stateQ == StDone) || ((stateQ == StIdle) && !req);
   assign bus.sramDqOe  = busy && isWrQ;
   assign bus.sramWeN   = !(busy && isWrQ);
   assign bus.sramOeN   = !(busy && !isWrQ);
   assign bus.sramAddr  = sramAddrQ;
   assign bus.sramDqOut = dqOutQ;
   assign bus.readData  = readDataQ;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: cycle-indexed expectations for each access
// plus a word-level memory model; a second instance covers WAIT_CYCLES=1 and wrap.
module tb_mem_access_ctrl;
   localparam int unsigned BASE = 1024;
   localparam int unsigned AW   = 18;
   localparam int          W    = 2;
   localparam int unsigned NIDX = 1 << (AW - 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(AW)) bus0 ();
   mem_access_ctrl_if #(.ADDR_W(AW)) bus1 ();

   mem_access_ctrl #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .bus(bus0.slave)
   );
   mem_access_ctrl #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave)
   );

   // Device-side SRAM model; refMem is the bench's expectation of its contents.
   logic [15:0] sram   [0:1023];
   logic [15:0] refMem [0:1023];
   always @(posedge clk) begin
      if (!bus0.sramWeN) sram[bus0.sramAddr[9:0]] <= bus0.sramDqOut;
   end
   assign bus0.sramDqIn = sram[bus0.sramAddr[9:0]];
   assign bus1.sramDqIn = 16'h5A5A;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] lastRead = 32'd0;

   task automatic runAccess(input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] wd);
      int unsigned idx, loA, expA;
      logic [31:0] expRd;
      logic [3:0]  ctl, expCtl;
      bit          hi;
      idx   = ((addr - BASE) >> 2) % NIDX;
      loA   = idx * 2;
      expRd = {refMem[loA+1], refMem[loA]};
      @(posedge clk);
      #1;
      bus0.rdEn = rd; bus0.wrEn = wr; bus0.address = addr; bus0.writeData = wd;
      for (int k = 0; k <= 2 * W + 1; k++) begin
         @(negedge clk);
         ctl = {bus0.ready, bus0.sramWeN, bus0.sramOeN, bus0.sramDqOe};
         if (k == 0) begin
            total++;
            if (ctl !== 4'b0110) begin
               bad++; $display("FAIL req_cycle0 ctl got=%b want=0110", ctl);
            end
         end else if (k <= 2 * W) begin
            hi     = (k > W);
            expA   = loA + (hi ? 1 : 0);
            expCtl = wr ? 4'b0011 : 4'b0100;
            total++;
            if (ctl !== expCtl) begin
               bad++; $display("FAIL half_ctl k=%0d got=%b want=%b", k, ctl, expCtl);
            end
            total++;
            if (bus0.sramAddr !== AW'(expA)) begin
               bad++; $display("FAIL half_addr k=%0d got=%0d want=%0d", k, bus0.sramAddr, expA);
            end
            if (wr) begin
               total++;
               if (bus0.sramDqOut !== (hi ? wd[31:16] : wd[15:0])) begin
                  bad++; $display("FAIL half_dq k=%0d got=%h want=%h", k, bus0.sramDqOut,
                                  hi ? wd[31:16] : wd[15:0]);
               end
            end
         end else begin
            total++;
            if (ctl !== 4'b1110) begin
               bad++; $display("FAIL done_ctl got=%b want=1110", ctl);
            end
            total++;
            if (bus0.readData !== (wr ? lastRead : expRd)) begin
               bad++; $display("FAIL done_rdata got=%h want=%h", bus0.readData,
                               wr ? lastRead : expRd);
            end
         end
      end
      if (wr) begin
         refMem[loA]   = wd[15:0];
         refMem[loA+1] = wd[31:16];
         total++;
         if ({sram[loA+1], sram[loA]} !== wd) begin
            bad++; $display("FAIL sram_content got=%h want=%h", {sram[loA+1], sram[loA]}, wd);
         end
      end else begin
         lastRead = expRd;
      end
   endtask

   task automatic idleCycles(input int n);
      @(posedge clk);
      #1;
      bus0.rdEn = 1'b0; bus0.wrEn = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         total++;
         if ({bus0.ready, bus0.sramWeN, bus0.sramOeN, bus0.sramDqOe, bus0.readData} !==
             {4'b1110, lastRead}) begin
            bad++; $display("FAIL idle ctl/rdata got=%b/%h want=1110/%h",
                            {bus0.ready, bus0.sramWeN, bus0.sramOeN, bus0.sramDqOe},
                            bus0.readData, lastRead);
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      total++;
      if ({bus0.ready, bus0.sramWeN, bus0.sramOeN, bus0.sramDqOe} !== 4'b1110 ||
          bus0.readData !== 32'd0 || bus0.sramAddr !== '0 || bus0.sramDqOut !== 16'd0) begin
         bad++; $display("FAIL reset_state rdy=%b rd=%h addr=%0d dq=%h want 1/0/0/0",
                         bus0.ready, bus0.readData, bus0.sramAddr, bus0.sramDqOut);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      idleCycles(2);
   endtask

   task automatic test_store;
      runAccess(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
      idleCycles(1);
   endtask

   task automatic test_load;
      sram[2] = 16'h1234; sram[3] = 16'hABCD;
      refMem[2] = 16'h1234; refMem[3] = 16'hABCD;
      runAccess(1'b0, 1'b1, 32'd1028, 32'd0);
      total++;
      if (lastRead !== 32'hABCD1234) begin
         bad++; $display("FAIL load_model got=%h want=abcd1234", lastRead);
      end
      idleCycles(3);
   endtask

   task automatic test_both;
      runAccess(1'b1, 1'b1, 32'd1040, 32'h0BAD_F00D);
      idleCycles(1);
   endtask

   task automatic test_back_to_back;
      runAccess(1'b1, 1'b0, 32'd1100, 32'hCAFE_1234);
      runAccess(1'b0, 1'b1, 32'd1100, 32'd0);
      idleCycles(1);
   endtask

   task automatic test_random;
      logic [31:0] a, d;
      bit          wr;
      for (int i = 0; i < 24; i++) begin
         a  = BASE + ($urandom_range(0, 255) * 4) + $urandom_range(0, 3);
         d  = $urandom;
         wr = $urandom_range(0, 1) == 1;
         runAccess(wr, ~wr | ($urandom_range(0, 3) == 0), a, d);
         if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 2));
      end
      idleCycles(1);
   endtask

   task automatic test_reset_mid;
      @(posedge clk);
      #1;
      bus0.wrEn = 1'b1; bus0.address = 32'd1200; bus0.writeData = 32'h1111_2222;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus0.sramWeN !== 1'b0) begin
         bad++; $display("FAIL mid_lo_we got=%b want=0", bus0.sramWeN);
      end
      #1;
      rst = 1'b0; bus0.wrEn = 1'b0;
      #1;
      total++;
      if ({bus0.ready, bus0.sramWeN, bus0.sramOeN, bus0.sramDqOe} !== 4'b1110 ||
          bus0.readData !== 32'd0) begin
         bad++; $display("FAIL async_reset ctl=%b rd=%h want=1110/0",
                         {bus0.ready, bus0.sramWeN, bus0.sramOeN, bus0.sramDqOe},
                         bus0.readData);
      end
      lastRead = 32'd0;
      @(posedge clk);
      #1 rst = 1'b1;
      idleCycles(2);
   endtask

   task automatic test_wrap;
      logic [31:0] wd;
      wd = 32'h7654_3210;
      for (int op = 0; op < 2; op++) begin
         @(posedge clk);
         #1;
         bus1.wrEn = (op == 0); bus1.rdEn = (op == 1);
         bus1.address = BASE + (32'd1 << AW) * 2; bus1.writeData = wd;
         for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (bus1.ready !== (k == 3)) begin
               bad++; $display("FAIL wrap_ready op=%0d k=%0d got=%b", op, k, bus1.ready);
            end
            if (k == 1 || k == 2) begin
               total++;
               if (bus1.sramAddr !== AW'(k - 1)) begin
                  bad++; $display("FAIL wrap_addr k=%0d got=%0d want=%0d", k, bus1.sramAddr,
                                  k - 1);
               end
               if (op == 0) begin
                  total++;
                  if (bus1.sramDqOut !== (k == 2 ? wd[31:16] : wd[15:0])) begin
                     bad++; $display("FAIL wrap_dq k=%0d got=%h", k, bus1.sramDqOut);
                  end
               end
            end
         end
         if (op == 1) begin
            total++;
            if (bus1.readData !== 32'h5A5A5A5A) begin
               bad++; $display("FAIL wrap_rdata got=%h want=5a5a5a5a", bus1.readData);
            end
         end
         @(posedge clk);
         #1;
         bus1.wrEn = 1'b0; bus1.rdEn = 1'b0;
      end
   endtask

   initial begin
      bus0.rdEn = 1'b0; bus0.wrEn = 1'b0; bus0.address = 32'd0; bus0.writeData = 32'd0;
      bus1.rdEn = 1'b0; bus1.wrEn = 1'b0; bus1.address = 32'd0; bus1.writeData = 32'd0;
      for (int i = 0; i < 1024; i++) begin
         sram[i]   = 16'($urandom);
         refMem[i] = sram[i];
      end
      test_reset();
      test_store();
      test_load();
      test_both();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
